// File: rtl/branch_pc_unit.sv
// Program counter with N-source branch operand select, absolute or PC-relative
// targets, and a Moore start/run/flush/done controller.
module branch_pc_unit #(
  parameter  int PC_W      = 10,
  parameter  int DATA_W    = 8,
  parameter  int NSRC      = 4,
  parameter  int FLUSH_CYC = 1,
  localparam int SEL_W     = $clog2(NSRC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   halt,
  input  logic                   stall,
  input  logic                   branch,
  input  logic                   cond,
  input  logic                   brmode,
  input  logic [SEL_W-1:0]       brsel,
  input  logic [NSRC*DATA_W-1:0] brsrc,
  output logic [PC_W-1:0]        pc,
  output logic                   flush,
  output logic                   taken,
  output logic                   done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int         NSLOT      = 1 << SEL_W;
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYC);

  state_t                         state_reg;
  logic [PC_W-1:0]                pc_reg;
  logic [3:0]                     cnt_reg;
  logic                           taken_reg;
  logic                           flush_reg;
  logic                           done_reg;

  logic [NSLOT-1:0][DATA_W-1:0]   slot;
  logic [DATA_W-1:0]              op;
  logic [PC_W-1:0]                op_abs;
  logic [PC_W-1:0]                op_rel;
  logic [PC_W-1:0]                target;

  // Out-of-range select slots alias source 0, so the mux needs no range compare.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi < NSRC) begin : g_live
        assign slot[gi] = brsrc[gi*DATA_W +: DATA_W];
      end else begin : g_alias
        assign slot[gi] = brsrc[DATA_W-1:0];
      end
    end
  endgenerate

  assign op = slot[brsel];

  generate
    if (DATA_W >= PC_W) begin : g_trunc
      assign op_abs = op[PC_W-1:0];
      assign op_rel = op[PC_W-1:0];
    end else begin : g_ext
      assign op_abs = {{(PC_W-DATA_W){1'b0}}, op};
      assign op_rel = {{(PC_W-DATA_W){op[DATA_W-1]}}, op};
    end
  endgenerate

  assign target = brmode ? (pc_reg + op_rel) : op_abs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= '0;
      cnt_reg   <= '0;
      taken_reg <= 1'b0;
      flush_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      taken_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            pc_reg    <= '0;
            state_reg <= RUN;
            done_reg  <= 1'b0;
          end
        end
        RUN: begin
          if (stall) begin
            // hold everything
          end else if (halt) begin
            state_reg <= DONE;
            done_reg  <= 1'b1;
          end else if (branch && cond) begin
            pc_reg    <= target;
            taken_reg <= 1'b1;
            if (FLUSH_CYC > 0) begin
              state_reg <= FLUSH;
              cnt_reg   <= FLUSH_INIT;
              flush_reg <= 1'b1;
            end
          end else begin
            pc_reg <= pc_reg + PC_W'(1);
          end
        end
        FLUSH: begin
          if (!stall) begin
            cnt_reg <= cnt_reg - 4'd1;
            // <=1 also recovers if the counter were ever found at zero here
            if (cnt_reg <= 4'd1) begin
              cnt_reg   <= '0;
              state_reg <= RUN;
              flush_reg <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          flush_reg <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign pc    = pc_reg;
  assign flush = flush_reg;
  assign taken = taken_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Bench for branch_pc_unit: two instances (defaults, and NSRC=3/FLUSH_CYC=3)
// driven with shared stimulus and compared against a behavioural model.
module tb_branch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, halt, stall, branch, cond, brmode;
  logic [1:0]  brsel;
  logic [31:0] src_bus;

  logic [9:0]  pc0, pc1;
  logic        fl0, fl1, tk0, tk1, dn0, dn1;

  int checks   = 0;
  int failures = 0;
  bit cmp_on   = 0;

  // model state per instance: mode 0 idle, 1 run, 2 flushing, 3 done
  int m_mode [2] = '{0, 0};
  int m_pc   [2] = '{0, 0};
  int m_left [2] = '{0, 0};
  bit m_taken[2] = '{0, 0};
  int m_nsrc [2] = '{4, 3};
  int m_fl   [2] = '{1, 3};

  always #5 clk = ~clk;

  branch_pc_unit dut0 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .cond(cond), .brmode(brmode), .brsel(brsel),
    .brsrc(src_bus), .pc(pc0), .flush(fl0), .taken(tk0), .done(dn0)
  );

  branch_pc_unit #(.NSRC(3), .FLUSH_CYC(3)) dut1 (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .stall(stall),
    .branch(branch), .cond(cond), .brmode(brmode), .brsel(brsel),
    .brsrc(src_bus[23:0]), .pc(pc1), .flush(fl1), .taken(tk1), .done(dn1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_pc[k] = 0; m_left[k] = 0; m_taken[k] = 0;
    end
  endtask

  task automatic model_step(input int k);
    int s, op, off;
    bit tk;
    tk = 0;
    s  = int'(brsel);
    if (s >= m_nsrc[k]) s = 0;
    op  = int'(src_bus[8*s +: 8]);
    off = (op >= 128) ? op - 256 : op;
    case (m_mode[k])
      0, 3: if (start) begin m_pc[k] = 0; m_mode[k] = 1; end
      1: begin
        if (stall) begin
        end else if (halt) begin
          m_mode[k] = 3;
        end else if (branch && cond) begin
          m_pc[k] = brmode ? ((m_pc[k] + off + 1024) % 1024) : op;
          tk = 1;
          if (m_fl[k] > 0) begin m_mode[k] = 2; m_left[k] = m_fl[k]; end
        end else begin
          m_pc[k] = (m_pc[k] + 1) % 1024;
        end
      end
      2: if (!stall) begin
        m_left[k]--;
        if (m_left[k] == 0) m_mode[k] = 1;
      end
      default: ;
    endcase
    m_taken[k] = tk;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // Outputs only move on posedge or reset, so the falling edge is a stable sample point.
  always @(negedge clk) begin
    if (cmp_on) begin
      check("pc0",    32'(pc0), 32'(m_pc[0]));
      check("flush0", 32'(fl0), 32'(m_mode[0] == 2));
      check("taken0", 32'(tk0), 32'(m_taken[0]));
      check("done0",  32'(dn0), 32'(m_mode[0] == 3));
      check("pc1",    32'(pc1), 32'(m_pc[1]));
      check("flush1", 32'(fl1), 32'(m_mode[1] == 2));
      check("taken1", 32'(tk1), 32'(m_taken[1]));
      check("done1",  32'(dn1), 32'(m_mode[1] == 3));
      $display("cyc t=%0t pc0=%03h f%0b t%0b d%0b | pc1=%03h f%0b t%0b d%0b",
               $time, pc0, fl0, tk0, dn0, pc1, fl1, tk1, dn1);
    end
  end

  task automatic step(input bit st, input bit ha, input bit sl, input bit br,
                      input bit cd, input bit md, input logic [1:0] sel,
                      input logic [31:0] src);
    @(negedge clk);
    start = st; halt = ha; stall = sl; branch = br; cond = cd; brmode = md;
    brsel = sel; src_bus = src;
    @(posedge clk);
    #1;
  endtask

  task automatic nop();
    step(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
  endtask

  task automatic async_reset_pulse(input bit lit);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    if (lit) begin
      check("arst_pc0",    32'(pc0), 32'h0);
      check("arst_flush0", 32'(fl0), 32'h0);
      check("arst_taken0", 32'(tk0), 32'h0);
      check("arst_pc1",    32'(pc1), 32'h0);
      check("arst_flush1", 32'(fl1), 32'h0);
    end
    start = 0; halt = 0; stall = 0; branch = 0; cond = 0;
    @(negedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 0; halt = 0; stall = 0; branch = 0; cond = 0; brmode = 0;
    brsel = 2'd0; src_bus = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc0", 32'(pc0), 32'h0);
    check("rst_flags0", {29'h0, fl0, tk0, dn0}, 32'h0);
    @(negedge clk);
    #1 reset = 1'b0;
    cmp_on = 1;

    // start and sequential fetch
    step(1, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    check("start_pc0", 32'(pc0), 32'h0);
    repeat (3) nop();
    check("seq_pc0", 32'(pc0), 32'h3);
    repeat (2) nop();

    // absolute branch from 5 to 0x40 via source 2
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0040_0000);
    check("abs_pc0", 32'(pc0), 32'h040);
    check("abs_taken0", 32'(tk0), 32'h1);
    check("abs_flush0", 32'(fl0), 32'h1);
    check("abs_flush1", 32'(fl1), 32'h1);
    nop();
    check("post_taken0", 32'(tk0), 32'h0);
    nop();
    check("resume_pc0", 32'(pc0), 32'h041);
    check("long_flush1", 32'(fl1), 32'h1);
    check("long_pc1", 32'(pc1), 32'h040);
    nop();

    // relative branches, including wrap below zero, then increment wrap
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0010_0000);
    nop();
    step(0, 0, 0, 1, 1, 1, 2'd1, 32'h0000_FC00);
    check("rel_pc0", 32'(pc0), 32'h00C);
    nop();
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0002_0000);
    nop();
    step(0, 0, 0, 1, 1, 1, 2'd1, 32'h0000_FC00);
    check("relwrap_pc0", 32'(pc0), 32'h3FE);
    nop();
    nop();
    nop();
    check("incwrap_pc0", 32'(pc0), 32'h000);

    // not taken, stalled branch, released branch
    step(0, 0, 0, 1, 0, 0, 2'd2, 32'h0040_0000);
    check("nt_pc0", 32'(pc0), 32'h001);
    check("nt_taken0", 32'(tk0), 32'h0);
    step(0, 0, 1, 1, 1, 0, 2'd2, 32'h0080_0000);
    check("stall_pc0", 32'(pc0), 32'h001);
    check("stall_taken0", 32'(tk0), 32'h0);
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0080_0000);
    check("unstall_pc0", 32'(pc0), 32'h080);
    check("unstall_taken0", 32'(tk0), 32'h1);
    repeat (4) nop();

    // select 3: valid on the 4-source instance, falls back to source 0 on the 3-source one
    step(0, 0, 0, 1, 1, 0, 2'd3, 32'h7700_0021);
    check("sel3_pc0", 32'(pc0), 32'h077);
    check("sel3_pc1", 32'(pc1), 32'h021);
    repeat (4) nop();

    // halt, hold, then restart
    step(0, 1, 0, 0, 0, 0, 2'd0, 32'h0);
    check("halt_done0", 32'(dn0), 32'h1);
    check("halt_done1", 32'(dn1), 32'h1);
    repeat (5) nop();
    check("hold_pc0", 32'(pc0), 32'h07A);
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0040_0000);
    check("done_ignore_pc0", 32'(pc0), 32'h07A);
    step(1, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    check("restart_pc0", 32'(pc0), 32'h000);
    check("restart_done0", 32'(dn0), 32'h0);

    // stall in the middle of the long flush window
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0033_0000);
    nop();
    step(0, 0, 1, 0, 0, 0, 2'd0, 32'h0);
    step(0, 0, 1, 0, 0, 0, 2'd0, 32'h0);
    nop();
    check("stall_flush1", 32'(fl1), 32'h1);
    nop();
    check("stall_flush_end1", 32'(fl1), 32'h0);

    // async reset in the middle of a flush
    step(0, 0, 0, 1, 1, 0, 2'd2, 32'h0055_0000);
    async_reset_pulse(1);
    repeat (3) nop();
    check("idle_pc0", 32'(pc0), 32'h0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset_pulse(0);
      end else begin
        step($urandom_range(0, 5) == 0, $urandom_range(0, 23) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), $urandom);
      end
    end

    @(negedge clk);
    cmp_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_pc_unit.md
Name: branch_pc_unit

Overview:
Parametrised program-counter and branch-select unit for the 8-bit core. It replaces the fixed two-input branch multiplexer with an N-source branch-operand select, absolute or PC-relative targets, and a registered PC. A Moore state machine controls start, halt, stall and a configurable post-branch flush window. It sits between the register file/ALU flag outputs and the instruction-memory address port.

Parameters:
PC_W, 10, program-counter width in bits.
DATA_W, 8, width of each branch operand source.
NSRC, 4, number of branch operand sources (>=2; need not be a power of 2).
FLUSH_CYC, 1, cycles of flush after a taken branch (0..15).
SEL_W, $clog2(NSRC), derived select width; not overridden.

Ports:
CLK  in  1  clock; all state updates on rising edge.
Reset  in  1  asynchronous, active-high reset.
Start  in  1  begin execution from PC=0 (sampled in IDLE/DONE).
Halt  in  1  stop execution (sampled in RUN only).
Stall  in  1  freeze PC and state (RUN and FLUSH).
Branch  in  1  current instruction is a branch.
Cond  in  1  branch condition flag from ALU.
BrMode  in  1  0 = absolute target, 1 = PC-relative target.
BrSel  in  SEL_W  branch operand source index.
BrSrc  in  NSRC*DATA_W  packed operands; source i = bits [i*DATA_W +: DATA_W].
PC  out  PC_W  registered program counter.
Flush  out  1  high while in FLUSH (squash fetched instruction).
Taken  out  1  one-cycle registered pulse after a taken branch.
Done  out  1  high while in DONE.

Behaviour:
- Reset (async, immediate): state=IDLE, PC=0, Flush=0, Taken=0, Done=0, flush counter=0. Reset mid-operation aborts any branch or flush.
- States: IDLE, RUN, FLUSH, DONE. Flush = (state==FLUSH); Done = (state==DONE). Both are Moore outputs.
- IDLE: PC held. Start=1 -> PC<=0, RUN.
- RUN priority, per edge: Stall > Halt > taken branch > increment.
  - Stall=1: PC and state held; Branch and Halt ignored that cycle.
  - Halt=1: DONE, PC held.
  - Branch=1 and Cond=1: PC<=target, Taken<=1. If FLUSH_CYC>0, go to FLUSH with counter=FLUSH_CYC; otherwise stay in RUN.
  - Otherwise: PC<=PC+1, modulo 2^PC_W (0x3FF -> 0x000).
- Taken: 1 for exactly the cycle after the branch edge; 0 on every other edge.
- Operand select: op = source BrSel. If BrSel>=NSRC, use source 0.
- Target:
  - Absolute: op zero-extended to PC_W, or truncated to the low PC_W bits if DATA_W>PC_W.
  - Relative: PC + sign-extended op, modulo 2^PC_W. PC is the current registered value.
- FLUSH: PC held. Counter decrements each non-stalled edge; Stall freezes the counter. Go to RUN on the edge where the counter goes 1->0. Branch and Halt are ignored during FLUSH.
- DONE: PC held. Start=1 -> PC<=0, RUN; Done drops on that edge.
- Start is ignored in RUN and FLUSH.
- Combinational path: target from BrSrc/BrSel/PC to PC register D only; no combinational input-to-output path.

Test Plan:
(Defaults PC_W=10, DATA_W=8, NSRC=4, FLUSH_CYC=1.)
1. Reset, then Start for 1 cycle -> PC = 0,1,2,3 on successive edges; Flush=Taken=Done=0.
2. At PC=5: Branch=1, Cond=1, BrMode=0, BrSel=2, source2=0x40 -> next PC=0x040, Taken=1 and Flush=1 for one cycle, then PC=0x041, 0x042.
3. BrMode=1 at PC=0x010, BrSel=1, source1=0xFC -> PC=0x00C. At PC=0x002 with offset 0xFC -> PC=0x3FE (wrap). At PC=0x3FF with no branch -> PC=0x000.
4. Non-branch cases:
   - Branch=1, Cond=0 at PC=7 -> PC=8, no Taken, no Flush.
   - Stall=1 with Branch=Cond=1 -> PC held, no Taken.
   - Release Stall -> branch taken.
   - BrSel=3 with NSRC=3 -> source 0 used.
5. Halt at PC=9 -> Done=1 and PC=9 held for 5 cycles, with Branch/Start toggling only after the hold. Then Start -> PC=0, Done=0. Rerun with FLUSH_CYC=3: Flush high for exactly 3 cycles; Stall in mid-flush extends it by the number of stall cycles.
6. Assert Reset asynchronously mid-FLUSH, between edges -> PC=0, Flush=0, Taken=0 immediately; state IDLE; no PC change until Start.
